// File: rtl/audio_pkg.sv
// Shared sizing constants and types for the packed-audio unpacking path.
package audio_pkg;
   localparam int SIZE              = 8;
   localparam int INPUT_SIZE        = 512;
   localparam int SAMPLES_PER_INPUT = INPUT_SIZE / SIZE;
   localparam int SAMPLES           = 1048576;
   localparam int COUNT_W           = $clog2(SAMPLES);

   typedef logic [SIZE-1:0] sample_t;
endpackage

// File: rtl/word_fifo.sv
// Small power-of-two FIFO holding packed words with their frame-end flag.
module word_fifo #(
   parameter  int WIDTH = 512,
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_last,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_last,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic             mem_last [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem_data[rd_ptr];
   assign head_last = mem_last[rd_ptr];

   // Storage is left unreset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_data[wr_ptr] <= push_data;
         mem_last[wr_ptr] <= push_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/audio_unpacker.sv
// Unpacks wide packed words into a stream of samples, lane 0 first,
// tracking per-frame sample count and flagging the end of each frame.
module audio_unpacker #(
   parameter int SIZE       = audio_pkg::SIZE,
   parameter int INPUT_SIZE = audio_pkg::INPUT_SIZE,
   parameter int DEPTH      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [INPUT_SIZE-1:0]        in_data,
   input  logic                         in_valid,
   input  logic                         in_last,
   output logic                         in_ready,
   output logic [SIZE-1:0]              sample_out,
   output logic                         sample_valid,
   input  logic                         sample_ready,
   output logic                         frame_done,
   output logic [audio_pkg::COUNT_W-1:0] sample_count
);
   import audio_pkg::*;

   localparam int LANES  = INPUT_SIZE / SIZE;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [INPUT_SIZE-1:0] head_data;
   logic                  head_last;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic [LANE_W-1:0]     lane_idx;
   logic                  sample_xfer;
   logic                  word_done;
   logic                  frame_end;

   // in_ready comes only from registered occupancy, so a full buffer never
   // accepts even when the head word pops on the same edge.
   assign in_ready     = !fifo_full;
   assign sample_valid = !fifo_empty;
   assign sample_xfer  = sample_valid && sample_ready;
   assign word_done    = sample_xfer && (lane_idx == LAST_LANE);
   assign frame_end    = word_done && head_last;
   assign sample_out   = fifo_empty ? '0 : head_data[lane_idx*SIZE +: SIZE];

   word_fifo #(
      .WIDTH (INPUT_SIZE),
      .DEPTH (DEPTH)
   ) u_word_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data (in_data),
      .push_last (in_last),
      .pop       (word_done),
      .head_data (head_data),
      .head_last (head_last),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_idx     <= '0;
         sample_count <= '0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (sample_xfer) begin
            lane_idx     <= (lane_idx == LAST_LANE) ? '0 : lane_idx + LANE_W'(1);
            sample_count <= frame_end ? '0 : sample_count + COUNT_W'(1);
         end
      end
   end

   occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_audio_unpacker.sv
// Randomised bench for audio_unpacker against a queue-based sample-stream model.
module tb_audio_unpacker;
   import audio_pkg::*;

   localparam int DEPTH = 2;
   localparam int LANES = INPUT_SIZE / SIZE;

   typedef logic [30:0] vec_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [INPUT_SIZE-1:0] in_data = '0;
   logic                  in_valid = 1'b0;
   logic                  in_last = 1'b0;
   logic                  sample_ready = 1'b0;
   logic                  in_ready;
   sample_t               sample_out;
   logic                  sample_valid;
   logic                  frame_done;
   logic [COUNT_W-1:0]    sample_count;

   int tests = 0;
   int fails = 0;

   audio_unpacker #(.SIZE(SIZE), .INPUT_SIZE(INPUT_SIZE), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .frame_done   (frame_done),
      .sample_count (sample_count)
   );

   always #5 clk = ~clk;

   // Reference: buffered words as a queue, position within the head word,
   // samples emitted so far in the current frame, and the end-of-frame flag.
   logic [INPUT_SIZE-1:0] wq_data [$];
   bit                    wq_last [$];
   int                    m_pos;
   int                    m_count;
   bit                    m_fd;

   function automatic void model_reset();
      wq_data.delete();
      wq_last.delete();
      m_pos   = 0;
      m_count = 0;
      m_fd    = 1'b0;
   endfunction

   function automatic void model_edge(input bit push, input logic [INPUT_SIZE-1:0] d,
                                      input bit l, input bit xfer);
      bit fd = 1'b0;
      if (xfer) begin
         fd      = (m_pos == LANES - 1) && wq_last[0];
         m_count = fd ? 0 : (m_count + 1) % SAMPLES;
         m_pos++;
         if (m_pos == LANES) begin
            m_pos = 0;
            void'(wq_data.pop_front());
            void'(wq_last.pop_front());
         end
      end
      if (push) begin
         wq_data.push_back(d);
         wq_last.push_back(l);
      end
      m_fd = fd;
   endfunction

   function automatic vec_t exp_vec();
      sample_t s = '0;
      if (wq_data.size() > 0) s = wq_data[0][m_pos*SIZE +: SIZE];
      return {wq_data.size() < DEPTH, wq_data.size() > 0, s, COUNT_W'(m_count), m_fd};
   endfunction

   function automatic vec_t obs_vec();
      return {in_ready, sample_valid, sample_out, sample_count, frame_done};
   endfunction

   function automatic logic [INPUT_SIZE-1:0] rand_word();
      logic [INPUT_SIZE-1:0] w;
      for (int i = 0; i < INPUT_SIZE / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic drive(input bit v, input logic [INPUT_SIZE-1:0] d, input bit l, input bit r);
      @(negedge clk);
      in_valid     = v;
      in_data      = d;
      in_last      = l;
      sample_ready = r;
      #1;
   endtask

   task automatic advance();
      bit push = in_valid && (wq_data.size() < DEPTH);
      bit xfer = sample_ready && (wq_data.size() > 0);
      @(posedge clk);
      model_edge(push, in_data, in_last, xfer);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_data = rand_word(); in_last = 1'b1; sample_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      tests++; if (in_ready !== 1'b1)     begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_sample_valid got %b exp 0", sample_valid); end
      tests++; if (frame_done !== 1'b0)   begin fails++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
      tests++; if (sample_out !== '0)     begin fails++; $display("FAIL reset_sample_out got %h exp 0", sample_out); end
      tests++; if (sample_count !== '0)   begin fails++; $display("FAIL reset_sample_count got %0d exp 0", sample_count); end
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b1;
      model_reset();
      drive(0, '0, 0, 0);
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL after_release got %h exp %h", obs_vec(), exp_vec()); end
      advance();
   endtask

   task automatic test_single_frame();
      logic [INPUT_SIZE-1:0] w;
      for (int k = 0; k < LANES; k++) w[k*SIZE +: SIZE] = SIZE'(k + 1);
      drive(1, w, 1, 1);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_accept got %b exp 1", in_ready); end
      advance();
      for (int k = 0; k < LANES; k++) begin
         drive(0, '0, 0, 1);
         tests++;
         if ({sample_valid, sample_out, sample_count, frame_done} !== {1'b1, SIZE'(k + 1), COUNT_W'(k), 1'b0}) begin
            fails++;
            $display("FAIL single_lane%0d got v=%b s=%0d c=%0d fd=%b exp v=1 s=%0d c=%0d fd=0",
                     k, sample_valid, sample_out, sample_count, frame_done, k + 1, k);
         end
         advance();
      end
      drive(0, '0, 0, 1);
      tests++;
      if ({sample_valid, frame_done, sample_count} !== {1'b0, 1'b1, COUNT_W'(0)}) begin
         fails++;
         $display("FAIL single_frame_done got v=%b fd=%b c=%0d exp v=0 fd=1 c=0", sample_valid, frame_done, sample_count);
      end
      advance();
      drive(0, '0, 0, 1);
      tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL single_pulse_width got %b exp 0", frame_done); end
      advance();
   endtask

   task automatic test_backpressure();
      logic [INPUT_SIZE-1:0] w0, w1, w2;
      w0 = rand_word(); w1 = rand_word(); w2 = rand_word();
      drive(1, w0, 0, 0);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_first got %b exp 1", in_ready); end
      advance();
      drive(1, w1, 0, 0);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_second got %b exp 1", in_ready); end
      advance();
      drive(1, w2, 1, 0);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b exp 0", in_ready); end
      advance();
      for (int l = 0; l < LANES; l++) begin
         drive(1, w2, 1, 1);
         tests++;
         if ({in_ready, sample_out} !== {1'b0, w0[l*SIZE +: SIZE]}) begin
            fails++;
            $display("FAIL bp_hold_lane%0d got rdy=%b s=%h exp rdy=0 s=%h", l, in_ready, sample_out, w0[l*SIZE +: SIZE]);
         end
         advance();
      end
      drive(1, w2, 1, 1);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_third_accept got %b exp 1", in_ready); end
      advance();
      for (int c = 0; c < 4 * LANES && wq_data.size() > 0; c++) begin
         drive(0, '0, 0, 1);
         tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL bp_drain cycle %0d got %h exp %h", c, obs_vec(), exp_vec()); end
         advance();
      end
      drive(0, '0, 0, 0);
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL bp_end got %h exp %h", obs_vec(), exp_vec()); end
      advance();
   endtask

   task automatic test_random_stalls();
      localparam int NW = 24;
      int sent = 0;
      int got  = 0;
      logic [INPUT_SIZE-1:0] cur = rand_word();
      bit cl = ($urandom_range(3) == 0);
      for (int c = 0; c < NW * LANES * 6 && (sent < NW || wq_data.size() > 0); c++) begin
         bit v = (sent < NW) && ($urandom_range(3) != 0);
         bit r = 1'($urandom_range(1));
         drive(v, cur, cl, r);
         tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL stalls cycle %0d got %h exp %h", c, obs_vec(), exp_vec()); end
         if (sample_valid && sample_ready) got++;
         if (v && wq_data.size() < DEPTH) begin
            sent++;
            cur = rand_word();
            cl  = ($urandom_range(3) == 0);
         end
         advance();
      end
      tests++; if (got !== NW * LANES) begin fails++; $display("FAIL stalls_sample_total got %0d exp %0d", got, NW * LANES); end
      drive(0, '0, 0, 0);
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL stalls_end got %h exp %h", obs_vec(), exp_vec()); end
      advance();
   endtask

   task automatic test_back_to_back();
      localparam int NW = 6;
      int sent = 0;
      logic [INPUT_SIZE-1:0] cur = rand_word();
      for (int c = 0; c < NW * LANES + 20 && (sent < NW || wq_data.size() > 0); c++) begin
         bit v = (sent < NW);
         drive(v, cur, sent == NW - 1, 1);
         tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL b2b cycle %0d got %h exp %h", c, obs_vec(), exp_vec()); end
         if (c >= 1 && c <= NW * LANES) begin
            tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL b2b_throughput cycle %0d got %b exp 1", c, sample_valid); end
         end
         if (v && wq_data.size() < DEPTH) begin
            sent++;
            cur = rand_word();
         end
         advance();
      end
      drive(0, '0, 0, 0);
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL b2b_end got %h exp %h", obs_vec(), exp_vec()); end
      advance();
   endtask

   task automatic test_reset_midframe();
      logic [INPUT_SIZE-1:0] w1, w2, w3;
      int sent = 0;
      w1 = rand_word(); w2 = rand_word(); w3 = rand_word();
      for (int c = 0; c < 4 * LANES && m_count != LANES + 30; c++) begin
         bit v = (sent < 2);
         drive(v, (sent == 0) ? w1 : w2, 0, 1);
         tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL mid_run cycle %0d got %h exp %h", c, obs_vec(), exp_vec()); end
         if (v && wq_data.size() < DEPTH) sent++;
         advance();
      end
      tests++; if (m_count !== LANES + 30) begin fails++; $display("FAIL mid_reach_lane30 got %0d exp %0d", m_count, LANES + 30); end
      @(negedge clk);
      in_valid = 1'b0; sample_ready = 1'b0; rst_n = 1'b0;
      #1;
      tests++;
      if ({sample_valid, sample_out, in_ready, sample_count} !== {1'b0, SIZE'(0), 1'b1, COUNT_W'(0)}) begin
         fails++;
         $display("FAIL mid_async_reset got v=%b s=%h rdy=%b c=%0d exp v=0 s=0 rdy=1 c=0", sample_valid, sample_out, in_ready, sample_count);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, w3, 1, 0);
      advance();
      drive(0, '0, 0, 1);
      tests++;
      if ({sample_valid, sample_out} !== {1'b1, w3[SIZE-1:0]}) begin
         fails++;
         $display("FAIL mid_restart_lane0 got v=%b s=%h exp v=1 s=%h", sample_valid, sample_out, w3[SIZE-1:0]);
      end
      advance();
      drive(0, '0, 0, 0);
      tests++; if (sample_count !== COUNT_W'(1)) begin fails++; $display("FAIL mid_restart_count got %0d exp 1", sample_count); end
      advance();
      for (int c = 0; c < 2 * LANES && wq_data.size() > 0; c++) begin
         drive(0, '0, 0, 1);
         tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL mid_drain cycle %0d got %h exp %h", c, obs_vec(), exp_vec()); end
         advance();
      end
      drive(0, '0, 0, 0);
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL mid_end got %h exp %h", obs_vec(), exp_vec()); end
      advance();
   endtask

   task automatic test_long_frame();
      localparam int NW = 48;
      int sent = 0;
      int pulses = 0;
      logic [INPUT_SIZE-1:0] cur = rand_word();
      for (int c = 0; c < NW * LANES + 20 && (sent < NW || wq_data.size() > 0); c++) begin
         bit v = (sent < NW);
         drive(v, cur, sent == NW - 1, 1);
         tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL long cycle %0d got %h exp %h", c, obs_vec(), exp_vec()); end
         if (frame_done === 1'b1) pulses++;
         if (wq_data.size() == 1 && m_pos == LANES - 1 && sent == NW) begin
            tests++;
            if (sample_count !== COUNT_W'(NW * LANES - 1)) begin
               fails++;
               $display("FAIL long_count_before_last got %0d exp %0d", sample_count, NW * LANES - 1);
            end
         end
         if (v && wq_data.size() < DEPTH) begin
            sent++;
            cur = rand_word();
         end
         advance();
      end
      drive(0, '0, 0, 0);
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL long_end got %h exp %h", obs_vec(), exp_vec()); end
      if (frame_done === 1'b1) pulses++;
      advance();
      drive(0, '0, 0, 0);
      if (frame_done === 1'b1) pulses++;
      advance();
      tests++; if (pulses !== 1) begin fails++; $display("FAIL long_frame_pulses got %0d exp 1", pulses); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_frame();
      test_backpressure();
      test_random_stalls();
      test_back_to_back();
      test_reset_midframe();
      test_long_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
